// File: rtl/scan_7seg_display.sv
// scan_7seg_display
//   Multiplexed 7-segment display scanner with selectable data pages,
//   leading-zero blanking, per-digit blinking and decimal points.
//
// Ports
//   clk        : clock, all state on posedge
//   rst_n      : asynchronous active-low reset
//   data       : PAGES pages of DIGITS hex nibbles; page p at
//                [(p+1)*DIGITS*4-1 : p*DIGITS*4], digit 0 is the top nibble
//   page_sel   : requested page, adopted at frame wrap; out-of-range ignored
//   dp_in      : decimal point request, bit i for digit i (active-high)
//   blank_lz   : leading-zero blanking enable
//   blink_en   : per-digit blink enable, bit DIGITS-1 for digit 0
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   select     : digit enable, active-low, bit DIGITS-1 drives digit 0
//   frame_done : one-cycle pulse when the last digit slot ends
module scan_7seg_display #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PAGES        = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned PSEL_W       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PAGES*DIGITS*4-1:0] data,
  input  logic [PSEL_W-1:0]         page_sel,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      blank_lz,
  input  logic [DIGITS-1:0]         blink_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [DIGITS-1:0]         select,
  output logic                      frame_done
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, idx_n, ridx;
  logic [PW-1:0] page, page_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;
  logic          tick, wrap;

  logic [DIGITS*4-1:0] pwords [PAGES];
  logic [DIGITS*4-1:0] pword;
  logic [3:0]          nibs [DIGITS];
  logic                lead_zero, blank;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   sel_n;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CW'(DIV - 1));
  assign wrap = tick && (32'(idx) == DIGITS - 1);

  always_comb begin
    idx_n   = idx;
    page_n  = page;
    bcnt_n  = bcnt;
    phase_n = phase;

    if (tick) idx_n = (32'(idx) == DIGITS - 1) ? '0 : idx + IW'(1);

    if (wrap) begin
      if (32'(page_sel) < PAGES) page_n = PW'(page_sel);
      if (bcnt == BW'(BLINK_FRAMES - 1)) begin
        bcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        bcnt_n = bcnt + BW'(1);
      end
    end

    // Output for the slot being entered uses next-state page/phase so the
    // first digit of a new frame already reflects the frame-wrap updates.
    for (int unsigned p = 0; p < PAGES; p++)
      pwords[p] = data[p*DIGITS*4 +: DIGITS*4];
    pword = pwords[page_n];
    for (int unsigned i = 0; i < DIGITS; i++)
      nibs[i] = pword[(DIGITS-1-i)*4 +: 4];

    lead_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (i <= 32'(idx_n) && nibs[i] != 4'd0) lead_zero = 1'b0;

    ridx  = IW'(DIGITS - 1) - idx_n;
    blank = (blank_lz && lead_zero && 32'(idx_n) != DIGITS - 1) ||
            (phase_n && blink_en[ridx]);

    seg_n       = blank ? '1 : hex2seg(nibs[idx_n]);
    dp_n        = blank ? 1'b1 : ~dp_in[idx_n];
    sel_n       = '1;
    sel_n[ridx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= IW'(DIGITS - 1);
      page       <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      seg        <= '1;
      dp         <= 1'b1;
      select     <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      idx        <= idx_n;
      page       <= page_n;
      bcnt       <= bcnt_n;
      phase      <= phase_n;
      frame_done <= wrap;
      if (tick) begin
        seg    <= seg_n;
        dp     <= dp_n;
        select <= sel_n;
      end
    end
  end

endmodule
